stream_demux2: RTL and testbench



---
 rtl/stream_demux2.sv | 99 +++++++++
 tb/tb_stream_demux2.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux2.sv
// stream_demux2: routes one valid/ready input stream to one of two outputs,
// chosen per word by in_sel. Each output owns a one-entry buffer and a
// wrapping count of words delivered.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   in_data/in_sel/in_valid input word, destination (0 -> out0, 1 -> out1), valid
//   in_ready                word accepted this cycle when in_valid is also high
//   outK_data/outK_valid    buffered word for consumer K and its valid flag
//   outK_ready              consumer K takes the word
//   cnt0, cnt1              words delivered on out0/out1, modulo 2^CW
module stream_demux2 #(
   parameter int unsigned SIZE = 32,
   parameter int unsigned CW   = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [SIZE-1:0] in_data,
   input  logic            in_sel,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [SIZE-1:0] out0_data,
   output logic            out0_valid,
   input  logic            out0_ready,
   output logic [SIZE-1:0] out1_data,
   output logic            out1_valid,
   input  logic            out1_ready,
   output logic [CW-1:0]   cnt0,
   output logic [CW-1:0]   cnt1
);

   logic            full0_q, full0_d;
   logic            full1_q, full1_d;
   logic [SIZE-1:0] data0_q, data0_d;
   logic [SIZE-1:0] data1_q, data1_d;
   logic [CW-1:0]   cnt0_q,  cnt0_d;
   logic [CW-1:0]   cnt1_q,  cnt1_d;
   logic            acc;
   logic            deq0;
   logic            deq1;

   // Only the selected buffer can stall the input; a full buffer whose
   // consumer is ready frees its slot at the same edge, so no bubble.
   always_comb begin
      in_ready = 1'b0;
      if (in_sel) in_ready = ~full1_q | out1_ready;
      else        in_ready = ~full0_q | out0_ready;
   end

   assign acc  = in_valid & in_ready;
   assign deq0 = full0_q & out0_ready;
   assign deq1 = full1_q & out1_ready;

   // Next-state for both buffers and counters.
   always_comb begin
      full0_d = full0_q;
      full1_d = full1_q;
      data0_d = data0_q;
      data1_d = data1_q;
      cnt0_d  = cnt0_q;
      cnt1_d  = cnt1_q;

      full0_d = (acc & ~in_sel) | (full0_q & ~out0_ready);
      full1_d = (acc &  in_sel) | (full1_q & ~out1_ready);

      // Data register keeps its last word after dequeue; it only loads on accept.
      if (acc & ~in_sel) data0_d = in_data;
      if (acc &  in_sel) data1_d = in_data;

      if (deq0) cnt0_d = cnt0_q + CW'(1);
      if (deq1) cnt1_d = cnt1_q + CW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         full0_q <= 1'b0;
         full1_q <= 1'b0;
         data0_q <= '0;
         data1_q <= '0;
         cnt0_q  <= '0;
         cnt1_q  <= '0;
      end else begin
         full0_q <= full0_d;
         full1_q <= full1_d;
         data0_q <= data0_d;
         data1_q <= data1_d;
         cnt0_q  <= cnt0_d;
         cnt1_q  <= cnt1_d;
      end
   end

   assign out0_valid = full0_q;
   assign out1_valid = full1_q;
   assign out0_data  = data0_q;
   assign out1_data  = data1_q;
   assign cnt0       = cnt0_q;
   assign cnt1       = cnt1_q;

endmodule

// File: tb/tb_stream_demux2.sv
// Testbench for stream_demux2: directed scenarios plus randomized traffic
// checked against a queue-based transaction model. A second instance with
// CW=4 shares all inputs and is used for the counter-wrap scenario.
module tb_stream_demux2;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] in_data;
   logic        in_sel;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out0_data, out1_data;
   logic        out0_valid, out1_valid;
   logic        out0_ready, out1_ready;
   logic [15:0] cnt0, cnt1;

   logic        w_in_ready;
   logic [31:0] w_out0_data, w_out1_data;
   logic        w_out0_valid, w_out1_valid;
   logic [3:0]  w_cnt0, w_cnt1;

   int checks = 0;
   int errors = 0;

   // Transaction model: words waiting on each output, and delivered counts.
   logic [31:0] q0[$];
   logic [31:0] q1[$];
   int          m_cnt0 = 0;
   int          m_cnt1 = 0;

   stream_demux2 #(.SIZE(32), .CW(16)) u_dut (
      .clk(clk), .reset(reset),
      .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
      .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
      .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
      .cnt0(cnt0), .cnt1(cnt1)
   );

   stream_demux2 #(.SIZE(32), .CW(4)) u_dut_w (
      .clk(clk), .reset(reset),
      .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(w_in_ready),
      .out0_data(w_out0_data), .out0_valid(w_out0_valid), .out0_ready(out0_ready),
      .out1_data(w_out1_data), .out1_valid(w_out1_valid), .out1_ready(out1_ready),
      .cnt0(w_cnt0), .cnt1(w_cnt1)
   );

   always #5 clk = ~clk;

   function automatic logic m_ready();
      if (in_sel) return (q1.size() == 0) || out1_ready;
      return (q0.size() == 0) || out0_ready;
   endfunction

   task automatic drive(input logic v, input logic s, input logic [31:0] d,
                        input logic r0, input logic r1);
      in_valid   = v;
      in_sel     = s;
      in_data    = d;
      out0_ready = r0;
      out1_ready = r1;
   endtask

   // Advance one clock edge and apply the same edge to the model.
   task automatic tick();
      logic        acc, d0, d1;
      logic [31:0] w;
      acc = in_valid && m_ready();
      d0  = (q0.size() > 0) && out0_ready;
      d1  = (q1.size() > 0) && out1_ready;
      @(posedge clk);
      #1;
      if (d0) begin w = q0.pop_front(); m_cnt0++; end
      if (d1) begin w = q1.pop_front(); m_cnt1++; end
      if (acc) begin
         if (in_sel) q1.push_back(in_data);
         else        q0.push_back(in_data);
      end
   endtask

   // Mid-cycle asynchronous reset pulse, released before the next edge.
   task automatic pulse_reset();
      #1 reset = 1'b1;
      #1 reset = 1'b0;
      q0.delete(); q1.delete();
      m_cnt0 = 0; m_cnt1 = 0;
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (out0_valid !== 1'b1 || out0_data !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL reset_preload out0_valid=%b data=%h want 1 deadbeef", out0_valid, out0_data);
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid got %b %b want 0 0", out0_valid, out1_valid);
      end
      checks++;
      if (out0_data !== 32'h0 || out1_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_data got %h %h want 0 0", out0_data, out1_data);
      end
      checks++;
      if (cnt0 !== 16'h0 || cnt1 !== 16'h0) begin
         errors++;
         $display("FAIL reset_cnt got %0d %0d want 0 0", cnt0, cnt1);
      end
      for (int s = 0; s < 2; s++) begin
         in_sel = s[0];
         #0.1;
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready sel=%0d got %b want 1", s, in_ready);
         end
      end
      reset = 1'b0;
      q0.delete(); q1.delete();
      m_cnt0 = 0; m_cnt1 = 0;
   endtask

   task automatic test_routing();
      drive(1'b1, 1'b0, 32'h00000011, 1'b1, 1'b1);
      tick();
      checks++;
      if (out0_valid !== 1'b1 || out0_data !== 32'h00000011) begin
         errors++;
         $display("FAIL route_out0 valid=%b data=%h want 1 00000011", out0_valid, out0_data);
      end
      drive(1'b1, 1'b1, 32'h00000022, 1'b1, 1'b1);
      tick();
      checks++;
      if (out1_valid !== 1'b1 || out1_data !== 32'h00000022) begin
         errors++;
         $display("FAIL route_out1 valid=%b data=%h want 1 00000022", out1_valid, out1_data);
      end
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      tick();
      checks++;
      if (cnt0 !== 16'd1 || cnt1 !== 16'd1) begin
         errors++;
         $display("FAIL route_cnt got %0d %0d want 1 1", cnt0, cnt1);
      end
   endtask

   task automatic test_backpressure();
      drive(1'b1, 1'b1, 32'hAAAA0001, 1'b1, 1'b0);
      #0.1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_first_ready got %b want 1", in_ready);
      end
      tick();
      drive(1'b1, 1'b1, 32'hAAAA0002, 1'b1, 1'b0);
      #0.1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_second_ready got %b want 0", in_ready);
      end
      tick();
      drive(1'b1, 1'b0, 32'h55550003, 1'b1, 1'b0);
      #0.1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_third_ready got %b want 1", in_ready);
      end
      tick();
      checks++;
      if (out0_valid !== 1'b1 || out0_data !== 32'h55550003) begin
         errors++;
         $display("FAIL bp_out0 valid=%b data=%h want 1 55550003", out0_valid, out0_data);
      end
      checks++;
      if (out1_valid !== 1'b1 || out1_data !== 32'hAAAA0001) begin
         errors++;
         $display("FAIL bp_out1_hold valid=%b data=%h want 1 aaaa0001", out1_valid, out1_data);
      end
      drive(1'b1, 1'b1, 32'hAAAA0002, 1'b1, 1'b1);
      #0.1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_resume_ready got %b want 1", in_ready);
      end
      tick();
      checks++;
      if (out1_valid !== 1'b1 || out1_data !== 32'hAAAA0002) begin
         errors++;
         $display("FAIL bp_out1_next valid=%b data=%h want 1 aaaa0002", out1_valid, out1_data);
      end
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      tick();
   endtask

   task automatic test_throughput();
      int start0, start1;
      start0 = m_cnt0;
      start1 = m_cnt1;
      for (int i = 0; i < 100; i++) begin
         drive(1'b1, 1'($urandom_range(1)), $urandom, 1'b1, 1'b1);
         #0.1;
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL tput_ready word=%0d got %b want 1", i, in_ready);
         end
         tick();
         checks++;
         if (out0_valid !== (q0.size() > 0) || out1_valid !== (q1.size() > 0) ||
             (q0.size() > 0 && out0_data !== q0[0]) ||
             (q1.size() > 0 && out1_data !== q1[0])) begin
            errors++;
            $display("FAIL tput_sb word=%0d got %b/%h %b/%h", i,
                     out0_valid, out0_data, out1_valid, out1_data);
         end
      end
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      tick();
      checks++;
      if (16'(cnt0 + cnt1) !== 16'(start0 + start1 + 100)) begin
         errors++;
         $display("FAIL tput_cnt got %0d want %0d", 16'(cnt0 + cnt1), 16'(start0 + start1 + 100));
      end
   endtask

   task automatic test_stress();
      logic [31:0] p0_data, p1_data;
      logic        p0_hold, p1_hold;
      int          accepted = 0;
      int          start_total;
      start_total = m_cnt0 + m_cnt1 + q0.size() + q1.size();
      for (int i = 0; i < 1000; i++) begin
         drive(1'($urandom_range(1)), 1'($urandom_range(1)), $urandom,
               1'($urandom_range(1)), 1'($urandom_range(1)));
         #0.1;
         checks++;
         if (in_ready !== m_ready()) begin
            errors++;
            $display("FAIL stress_in_ready cyc=%0d got %b want %b", i, in_ready, m_ready());
         end
         if (in_valid && m_ready()) accepted++;
         p0_hold = out0_valid && !out0_ready;
         p1_hold = out1_valid && !out1_ready;
         p0_data = out0_data;
         p1_data = out1_data;
         tick();
         checks++;
         if (out0_valid !== (q0.size() > 0) || (q0.size() > 0 && out0_data !== q0[0])) begin
            errors++;
            $display("FAIL stress_out0 cyc=%0d got %b/%h", i, out0_valid, out0_data);
         end
         checks++;
         if (out1_valid !== (q1.size() > 0) || (q1.size() > 0 && out1_data !== q1[0])) begin
            errors++;
            $display("FAIL stress_out1 cyc=%0d got %b/%h", i, out1_valid, out1_data);
         end
         checks++;
         if ((p0_hold && (out0_valid !== 1'b1 || out0_data !== p0_data)) ||
             (p1_hold && (out1_valid !== 1'b1 || out1_data !== p1_data))) begin
            errors++;
            $display("FAIL stress_stable cyc=%0d got %b/%h %b/%h", i,
                     out0_valid, out0_data, out1_valid, out1_data);
         end
         checks++;
         if (cnt0 !== 16'(m_cnt0) || cnt1 !== 16'(m_cnt1)) begin
            errors++;
            $display("FAIL stress_cnt cyc=%0d got %0d %0d want %0d %0d", i,
                     cnt0, cnt1, 16'(m_cnt0), 16'(m_cnt1));
         end
      end
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      tick();
      tick();
      checks++;
      if (out0_valid !== 1'b0 || out1_valid !== 1'b0 ||
          16'(cnt0 + cnt1) !== 16'(start_total + accepted)) begin
         errors++;
         $display("FAIL stress_drain valid=%b%b delivered=%0d want %0d", out0_valid, out1_valid,
                  16'(cnt0 + cnt1), 16'(start_total + accepted));
      end
   endtask

   task automatic test_counter_wrap();
      pulse_reset();
      for (int k = 1; k <= 17; k++) begin
         drive(1'b1, 1'b0, 32'(k), 1'b1, 1'b1);
         tick();
         drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
         tick();
         checks++;
         if (w_cnt0 !== 4'(k % 16)) begin
            errors++;
            $display("FAIL wrap_cnt0 word=%0d got %0d want %0d", k, w_cnt0, k % 16);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      #12 reset = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_routing();
      test_backpressure();
      test_throughput();
      test_stress();
      test_counter_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
